// File: rtl/instr_fetch_pkg.sv
// Shared types and default widths for the fetch stage, program counter and instruction memory.
// Consumed by instr_fetch; FETCH_TIMEOUT_EN builds use DEF_TIMEOUT.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: PC -> instruction memory read -> instruction register, with flush support.
// Optional WAIT timeout and sticky fetch_err when FETCH_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for fetch_req; imem_addr loaded and imem_rd pulsed on accept
// WAIT  | read outstanding; capture on imem_valid, abandon on flush (or timeout)
// DONE  | ir_valid and pc_incr_en high for this single cycle
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic               pc_incr_en,
  output logic               busy
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic               fetch_err
`endif
);

  fetch_state_e state, state_n;
  logic         launch;
  logic         capture;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Priority in WAIT: flush, then response, then timeout.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    capture = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fetch_req && !flush) begin
          state_n = WAIT;
          launch  = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          state_n = IDLE;
        end else if (imem_valid) begin
          state_n = DONE;
          capture = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          state_n = IDLE;
          tmo_hit = 1'b1;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // All outputs come straight from flops; imem_addr only moves on a new launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr  <= '0;
      imem_rd    <= 1'b0;
      ir_out     <= '0;
      ir_valid   <= 1'b0;
      pc_incr_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      imem_rd    <= launch;
      ir_valid   <= capture;
      pc_incr_en <= capture;
      busy       <= (state_n != IDLE);
      if (launch)  imem_addr <= pc_addr;
      if (capture) ir_out    <= imem_data;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Counts WAIT cycles; reaching TIMEOUT at the edge that ends the last allowed cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (launch)             tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_hit) fetch_err <= 1'b1;
    end
  end
`endif

endmodule
